// File: rtl/lotr_pkg.sv
// Shared types and constants for the multithreaded fetch scheduler.
package lotr_pkg;

  localparam int NUM_THREADS = 4;

  typedef logic [1:0] t_tid;

  localparam logic [1:0]  FETCH_COOLDOWN = 2'd3;
  localparam logic [31:0] PC_STEP        = 32'd4;

  // Fetch addresses are word aligned; low two bits of a target are dropped.
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rr_sel_4.sv
// Rotating-priority pick among 4 threads, starting just after the last issued one.
module rr_sel_4
  import lotr_pkg::*;
(
  input  logic [3:0] eligible,
  input  t_tid       last,
  output logic       grantValid,
  output t_tid       grantTid
);

  t_tid idx;

  // Walk from lowest to highest priority so the nearest successor of last wins.
  always_comb begin
    grantValid = 1'b0;
    grantTid   = '0;
    idx        = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + t_tid'(k);
      if (eligible[idx]) begin
        grantValid = 1'b1;
        grantTid   = idx;
      end
    end
  end

endmodule

// File: rtl/i_fetch_sched.sv
// Four-thread instruction fetch scheduler: round-robin issue with per-thread
// cooldown, branch redirect, and a registered Q101H stage.
module i_fetch_sched
  import lotr_pkg::*;
#(
  parameter logic [31:0] RST_PC_BASE   = 32'h0000_0000,
  parameter logic [31:0] RST_PC_STRIDE = 32'h0000_0000
) (
  input  logic        QClk,
  input  logic        RstQnnnH,
  input  logic [3:0]  ThreadEnQnnnH,
  input  logic        FetchStallQnnnH,
  input  logic        BranchValidQ103H,
  input  logic [1:0]  BranchThreadQ103H,
  input  logic [31:0] BranchTargetQ103H,
  output logic [31:0] PcQ100H,
  output logic        RdEnableQ100H,
  output logic [1:0]  ThreadQ100H,
  output logic        ValidQ101H,
  output logic [31:0] PcQ101H,
  output logic [1:0]  ThreadQ101H
);

  logic [31:0]            pcQ   [NUM_THREADS];
  logic [1:0]             coolQ [NUM_THREADS];
  t_tid                   lastQ;
  logic [NUM_THREADS-1:0] eligible;
  logic                   grantValid;
  t_tid                   grantTid;

  generate
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : gElig
      assign eligible[gi] = ThreadEnQnnnH[gi] && (coolQ[gi] == 2'd0);
    end
  endgenerate

  rr_sel_4 uSel (
    .eligible   (eligible),
    .last       (lastQ),
    .grantValid (grantValid),
    .grantTid   (grantTid)
  );

  assign RdEnableQ100H = grantValid && !FetchStallQnnnH && !RstQnnnH;
  assign PcQ100H       = grantValid ? pcQ[grantTid] : 32'd0;
  assign ThreadQ100H   = grantValid ? grantTid : 2'd0;

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pcQ[t]   <= RST_PC_BASE + RST_PC_STRIDE * 32'(t);
        coolQ[t] <= 2'd0;
      end
      lastQ       <= 2'd3;
      ValidQ101H  <= 1'b0;
      PcQ101H     <= 32'd0;
      ThreadQ101H <= 2'd0;
    end else begin
      if (!FetchStallQnnnH) begin
        for (int t = 0; t < NUM_THREADS; t++) begin
          if (coolQ[t] != 2'd0) coolQ[t] <= coolQ[t] - 2'd1;
        end
        if (RdEnableQ100H) begin
          pcQ[grantTid]   <= pcQ[grantTid] + PC_STEP;
          coolQ[grantTid] <= FETCH_COOLDOWN;
          lastQ           <= grantTid;
        end
        ValidQ101H  <= RdEnableQ100H;
        PcQ101H     <= PcQ100H;
        ThreadQ101H <= ThreadQ100H;
      end
      // Placed last so a redirect beats the +4 of the same thread, stalled or not.
      if (BranchValidQ103H) pcQ[BranchThreadQ103H] <= alignPc(BranchTargetQ103H);
    end
  end

endmodule

// File: tb/tb_i_fetch_sched.sv
// Scoreboard bench for i_fetch_sched: stimulus queues expected fetches, a monitor checks each issue.
module tb_i_fetch_sched;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  tid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        stall;
  logic        brValid;
  logic [1:0]  brThread;
  logic [31:0] brTarget;
  logic [31:0] pcQ100;
  logic        rdEn;
  logic [1:0]  thrQ100;
  logic        validQ101;
  logic [31:0] pcQ101;
  logic [1:0]  thrQ101;

  exp_t expQ[$];
  exp_t popped;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  i_fetch_sched #(
    .RST_PC_BASE   (32'h0000_0000),
    .RST_PC_STRIDE (32'h0000_0400)
  ) dut (
    .QClk              (clk),
    .RstQnnnH          (rst),
    .ThreadEnQnnnH     (en),
    .FetchStallQnnnH   (stall),
    .BranchValidQ103H  (brValid),
    .BranchThreadQ103H (brThread),
    .BranchTargetQ103H (brTarget),
    .PcQ100H           (pcQ100),
    .RdEnableQ100H     (rdEn),
    .ThreadQ100H       (thrQ100),
    .ValidQ101H        (validQ101),
    .PcQ101H           (pcQ101),
    .ThreadQ101H       (thrQ101)
  );

  // Monitor: every presented fetch must match the head of the expected queue.
  always @(negedge clk) begin
    if (rdEn) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got pc=%h tid=%0d, required no issue", pcQ100, thrQ100);
      end else begin
        popped = expQ.pop_front();
        if (pcQ100 !== popped.pc || thrQ100 !== popped.tid) begin
          errors++;
          $display("FAIL issue: got pc=%h tid=%0d, required pc=%h tid=%0d",
                   pcQ100, thrQ100, popped.pc, popped.tid);
        end else begin
          $display("issue pc=%h tid=%0d ok", pcQ100, thrQ100);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [1:0] tid);
    exp_t e;
    e.pc  = pc;
    e.tid = tid;
    expQ.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 4'hF; stall = 1'b0;
    brValid = 1'b0; brThread = 2'd0; brTarget = 32'd0;
    tick(2);

    // Reset state, with enables and stall present
    @(negedge clk);
    chk("rst_rden", 32'(rdEn), 32'd0);
    chk("rst_valid101", 32'(validQ101), 32'd0);
    chk("rst_pc101", pcQ101, 32'd0);
    chk("rst_thr101", 32'(thrQ101), 32'd0);
    tick(1);
    rst = 1'b0;

    // All threads, stride 0x400
    push(32'h000, 0); push(32'h400, 1); push(32'h800, 2); push(32'hC00, 3);
    push(32'h004, 0); push(32'h404, 1); push(32'h804, 2); push(32'hC04, 3);
    @(negedge clk);
    chk("post_rst_valid101", 32'(validQ101), 32'd0);
    tick(1);
    @(negedge clk);
    chk("q101_valid", 32'(validQ101), 32'd1);
    chk("q101_pc", pcQ101, 32'h0);
    chk("q101_thr", 32'(thrQ101), 32'd0);
    tick(7);

    // Stall for three cycles mid-stream
    push(32'h008, 0); push(32'h408, 1);
    tick(2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rden", 32'(rdEn), 32'd0);
      chk("stall_pc101", pcQ101, 32'h408);
      chk("stall_thr101", 32'(thrQ101), 32'd1);
      tick(1);
    end
    stall = 1'b0;
    push(32'h808, 2); push(32'hC08, 3); push(32'h00C, 0); push(32'h40C, 1);
    tick(4);

    // Only thread 2: one fetch every 4 cycles
    en = 4'b0100;
    push(32'h80C, 2); push(32'h810, 2); push(32'h814, 2);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t2_pattern", 32'(rdEn), (i % 4 == 0) ? 32'd1 : 32'd0);
      tick(1);
    end

    // Thread 1 redirect three cycles after issue, then redirect same cycle as issue
    en = 4'b0010;
    push(32'h410, 1); push(32'h1234, 1); push(32'h2000, 1);
    tick(3);
    brValid = 1'b1; brThread = 2'd1; brTarget = 32'h0000_1236;
    @(negedge clk);
    chk("redir_cool_rden", 32'(rdEn), 32'd0);
    tick(1);
    brTarget = 32'h0000_2000;
    tick(1);
    brValid = 1'b0;
    tick(4);

    // Redirect while stalled
    en = 4'b0000; stall = 1'b1;
    brValid = 1'b1; brThread = 2'd1; brTarget = 32'h0000_3000;
    tick(1);
    stall = 1'b0; brValid = 1'b0;
    tick(4);
    en = 4'b0010;
    push(32'h3000, 1);
    tick(1);
    en = 4'b0000;
    tick(1);

    // Thread 0 wraps past 0xFFFF_FFFC
    brValid = 1'b1; brThread = 2'd0; brTarget = 32'hFFFF_FFFE;
    tick(1);
    brValid = 1'b0; en = 4'b0001;
    push(32'hFFFF_FFFC, 0); push(32'h0000_0000, 0);
    tick(5);
    en = 4'b0000;

    // Reset mid-stream with thread 3 at 0xC40
    brValid = 1'b1; brThread = 2'd3; brTarget = 32'h0000_0C40;
    tick(1);
    brValid = 1'b0; en = 4'b1000;
    push(32'hC40, 3);
    tick(1);
    rst = 1'b1; en = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_rden", 32'(rdEn), 32'd0);
      tick(1);
    end
    rst = 1'b0;
    push(32'h000, 0); push(32'h400, 1);
    @(negedge clk);
    chk("midrst_valid101", 32'(validQ101), 32'd0);
    tick(2);

    // Disable all: in-flight entry completes, then valid drops
    en = 4'b0000;
    @(negedge clk);
    chk("dis_rden", 32'(rdEn), 32'd0);
    chk("dis_inflight_valid", 32'(validQ101), 32'd1);
    chk("dis_inflight_pc", pcQ101, 32'h400);
    chk("dis_inflight_thr", 32'(thrQ101), 32'd1);
    tick(1);
    @(negedge clk);
    chk("dis_valid101", 32'(validQ101), 32'd0);
    tick(1);

    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i_fetch_sched.md
I_FETCH_SCHED -- requirements
Module: i_fetch_sched

Interface
REQ-001 SHALL have parameter RST_PC_BASE, default 32'h0000_0000: reset PC of thread 0.
REQ-002 SHALL have parameter RST_PC_STRIDE, default 32'h0000_0000: reset PC offset between consecutive threads.
REQ-003 SHALL have port QClk  input  1  clock; the block uses this single clock.
REQ-004 SHALL have port RstQnnnH  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ThreadEnQnnnH  input  4  per-thread fetch enable.
REQ-006 SHALL have port FetchStallQnnnH  input  1  downstream stall; freezes the block.
REQ-007 SHALL have port BranchValidQ103H  input  1  redirect request.
REQ-008 SHALL have port BranchThreadQ103H  input  2  thread being redirected.
REQ-009 SHALL have port BranchTargetQ103H  input  32  redirect target PC.
REQ-010 SHALL have port PcQ100H  output  32  fetch address to instruction memory.
REQ-011 SHALL have port RdEnableQ100H  output  1  fetch read enable to instruction memory.
REQ-012 SHALL have port ThreadQ100H  output  2  thread ID of the Q100H fetch.
REQ-013 SHALL have port ValidQ101H  output  1  instruction data is valid in Q101H.
REQ-014 SHALL have port PcQ101H  output  32  PC of the Q101H instruction.
REQ-015 SHALL have port ThreadQ101H  output  2  thread ID of the Q101H instruction.

Function
REQ-016 SHALL keep one 32-bit PC register per thread (4 threads) and one 2-bit cooldown counter per thread.
REQ-017 Eligibility: thread t SHALL be eligible when ThreadEnQnnnH[t]=1 and its cooldown=0.
REQ-018 Selection: SHALL pick the first eligible thread in the order Last+1, Last+2, Last+3, Last+4 (mod 4), where Last is the last issued thread.
REQ-019 Issue: SHALL drive RdEnableQ100H=1 only when a thread is selected, FetchStallQnnnH=0 and RstQnnnH=0.
REQ-020 PcQ100H and ThreadQ100H SHALL be combinational from the selected thread; both SHALL be 0 when no thread is selected.
REQ-021 On issue of thread t, the block SHALL set PC[t]+=4 (wrap modulo 2^32), set cooldown[t]=3 and set Last=t.
REQ-022 Every non-stalled cycle, each non-zero cooldown SHALL decrement by 1, so a thread issued in cycle N becomes eligible again in cycle N+4.
REQ-023 Redirect: when BranchValidQ103H=1, PC[BranchThreadQ103H] SHALL load {BranchTargetQ103H[31:2],2'b00}.
REQ-024 A redirect SHALL take priority over the +4 update of the same thread in the same cycle.
REQ-025 A redirect SHALL apply even when FetchStallQnnnH=1.
REQ-026 Q101H: when not stalled, the block SHALL register ValidQ101H<=RdEnableQ100H, PcQ101H<=PcQ100H and ThreadQ101H<=ThreadQ100H.
REQ-027 Stall: when FetchStallQnnnH=1, the Q101H registers, Last and all cooldown counters SHALL hold, and no PC SHALL increment.
REQ-028 Disabling a thread SHALL stop its issues from the next selection; its PC SHALL hold and its in-flight Q101H entry SHALL complete.
REQ-029 With no thread enabled, RdEnableQ100H SHALL be 0 and ValidQ101H SHALL go to 0 on the next unstalled edge.

Reset
REQ-030 While RstQnnnH=1, on each edge: PC[t]<=RST_PC_BASE+t*RST_PC_STRIDE, all cooldowns<=0, Last<=3, ValidQ101H<=0, PcQ101H<=0, ThreadQ101H<=0.
REQ-031 Reset SHALL override stall and redirect; RdEnableQ100H SHALL be 0 during reset, and thread 0 SHALL issue first after reset.

Structure
REQ-032 lotr_pkg SHALL hold NUM_THREADS=4, typedef t_tid (logic [1:0]) and FETCH_COOLDOWN=3.
REQ-033 Rotating-priority selection SHALL be a sub-module rr_sel_4 (inputs: 4-bit eligible, Last; outputs: grant valid, grant tid).

Verification
REQ-034 All 4 threads enabled, BASE=0, STRIDE=0x400 -> PcQ100H sequence 0x0,0x400,0x800,0xC00,0x4,0x404...; RdEnableQ100H=1 every cycle.
REQ-035 Only thread 2 enabled -> one fetch every 4 cycles at 0x800,0x804,...; RdEnableQ100H pattern 1000 repeating.
REQ-036 Thread 1 issued at cycle N with redirect thread 1 to 0x1236 at N+3 -> thread 1 issues 0x1234 at cycle N+4.
REQ-037 FetchStallQnnnH=1 for 3 cycles mid-stream -> RdEnableQ100H=0, Q101H outputs frozen; sequence resumes with no skipped or duplicated PC.
REQ-038 Reset asserted mid-stream with thread 3 at 0xC40 -> after release thread 0 issues RST_PC_BASE first and ValidQ101H=0 on the first post-reset cycle.
REQ-039 PC[0]=0xFFFF_FFFC issues -> PC[0] wraps to 0x0000_0000.
